uart_param: RTL and testbench

Parametrised next-generation UART peripheral for the PicoSoC memory-mapped register bus. It has configurable data width and FIFO depth, 16x oversampled receive with mid-bit sampling and glitch rejection, 1 or 2 stop bits, and sticky error flags. Optional parity generation and checking is compiled in by macro. It sits beside the CPU bus decoder and drives the board serial pins.

---
 rtl/uart_param.sv | 356 +++++++++++++++++++++++++++++++++++
 tb/tb_uart_param.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_param.sv
// rtl/uart_param.sv - parametrised UART with memory-mapped registers and TX/RX FIFOs
// Optional parity generation/checking is compiled in with `define UART_PARAM_PARITY_EN.

// Synchronous FIFO; a push into a full FIFO only succeeds alongside a pop.
module uart_param_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic [LVL_W-1:0] level_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [LVL_W-1:0] lvl_q;
  logic             do_push, do_pop;

  assign full_o  = (lvl_q == LVL_W'(DEPTH));
  assign empty_o = (lvl_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_q];
  assign level_o = lvl_q;

  // Pointer and level bookkeeping; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PTR_W'(1);
      if (do_pop)  rd_q <= rd_q + PTR_W'(1);
      lvl_q <= lvl_q + LVL_W'(do_push) - LVL_W'(do_pop);
    end
  end

  // Storage array, written only on an accepted push.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end
endmodule

module uart_param #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  reg_we,
  input  logic [3:0]  reg_re,
  input  logic [3:0]  reg_addr,
  input  logic [31:0] reg_di,
  output logic [31:0] reg_do,
  output logic        ready,
  input  logic        uart_rx,
  output logic        uart_tx
);
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic        we_any, re_any, accept;
  logic        ready_q;
  logic [31:0] reg_do_q, rdata;
  logic [4:0]  cfg_q, cfg_wr;
  logic [15:0] div_q, div_cnt_q;
  logic        tick;
  logic        ovr_q, frm_q, perr_q;
  logic        par_en, par_odd;
  logic        unused_bits;

  // FIFO wiring
  logic                 tx_push, tx_pop, tx_full, tx_empty;
  logic [DATA_BITS-1:0] tx_dout;
  logic [LVL_W-1:0]     tx_lvl;
  logic                 rx_push, rx_pop, rx_full, rx_empty;
  logic [DATA_BITS-1:0] rx_dout;
  logic [LVL_W-1:0]     rx_lvl;

  // TX state
  state_t               tx_state_q, tx_state_d;
  logic [3:0]           tx_tcnt_q, tx_tcnt_d;
  logic [2:0]           tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_par_q, tx_par_d;
  logic                 tx_line_q, tx_line_d;

  // RX state
  logic                 rx_s1_q, rx_s2_q, rx_prev_q;
  state_t               rx_state_q, rx_state_d;
  logic [3:0]           rx_tcnt_q, rx_tcnt_d;
  logic [2:0]           rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_pbit_q, rx_pbit_d;
  logic                 rx_sample, rx_bit_end, frm_set, perr_set, ovr_set;

`ifdef UART_PARAM_PARITY_EN
  assign par_en  = cfg_q[1] ^ cfg_q[0];
  assign par_odd = cfg_q[1];
  assign cfg_wr  = reg_di[4:0];
`else
  assign par_en  = 1'b0;
  assign par_odd = 1'b0;
  assign cfg_wr  = {reg_di[4:2], 2'b00};
`endif

  assign we_any      = |reg_we;
  assign re_any      = |reg_re;
  assign accept      = (we_any || re_any) && !ready_q;
  assign tx_push     = accept && we_any && (reg_addr == 4'd3);
  assign rx_pop      = accept && !we_any && re_any && (reg_addr == 4'd4);
  assign ready       = ready_q;
  assign reg_do      = reg_do_q;
  assign uart_tx     = tx_line_q;
  assign unused_bits = ^reg_di[31:16];

  uart_param_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH), .LVL_W(LVL_W)) u_tx_fifo (
    .clk_i(clk), .reset_i(reset), .push_i(tx_push), .data_i(reg_di[DATA_BITS-1:0]),
    .pop_i(tx_pop), .data_o(tx_dout), .level_o(tx_lvl), .full_o(tx_full), .empty_o(tx_empty)
  );

  uart_param_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH), .LVL_W(LVL_W)) u_rx_fifo (
    .clk_i(clk), .reset_i(reset), .push_i(rx_push), .data_i(rx_shift_q),
    .pop_i(rx_pop), .data_o(rx_dout), .level_o(rx_lvl), .full_o(rx_full), .empty_o(rx_empty)
  );

  // Register read mux, evaluated on the acceptance clock (before any RX pop lands).
  always_comb begin
    rdata = '0;
    case (reg_addr)
      4'd0: rdata = {27'd0, cfg_q};
      4'd1: rdata = {16'd0, div_q};
      4'd2: rdata = {24'd0, (tx_state_q != S_IDLE), perr_q, frm_q, ovr_q,
                     rx_empty, rx_full, tx_empty, tx_full};
      4'd4: rdata = rx_empty ? 32'd0 : 32'(rx_dout);
      4'd5: rdata = ((32'(rx_lvl) & 32'hFF) << 16) | (32'(tx_lvl) & 32'hFF);
      default: rdata = '0;
    endcase
  end

  // One-cycle acknowledge; read data is only presented alongside ready, and a write wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q  <= 1'b0;
      reg_do_q <= '0;
    end else begin
      ready_q  <= accept;
      reg_do_q <= (accept && !we_any) ? rdata : 32'd0;
    end
  end

  // CFG and DIV configuration registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_q <= 5'h18;
      div_q <= '0;
    end else if (accept && we_any) begin
      if (reg_addr == 4'd0) cfg_q <= cfg_wr;
      if (reg_addr == 4'd1) div_q <= reg_di[15:0];
    end
  end

  // Sticky error flags: events set, writing 1 to STAT clears; a same-cycle event wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovr_q  <= 1'b0;
      frm_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      ovr_q  <= (ovr_q  & ~(accept && we_any && reg_addr == 4'd2 && reg_di[4])) | ovr_set;
      frm_q  <= (frm_q  & ~(accept && we_any && reg_addr == 4'd2 && reg_di[5])) | frm_set;
      perr_q <= (perr_q & ~(accept && we_any && reg_addr == 4'd2 && reg_di[6])) | perr_set;
    end
  end

  // Oversample tick generator; >= keeps a smaller DIV from wrapping the counter.
  always_ff @(posedge clk) begin
    if (reset) div_cnt_q <= '0;
    else       div_cnt_q <= tick ? 16'd0 : div_cnt_q + 16'd1;
  end
  assign tick = (div_cnt_q >= div_q);

  // TX state register; the line is registered so it only moves with state on a tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q <= S_IDLE;
      tx_tcnt_q  <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_line_q  <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_tcnt_q  <= tx_tcnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_line_q  <= tx_line_d;
    end
  end

  // TX next state: each bit spans 16 ticks; the FIFO pops as the frame starts.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_tcnt_d  = tx_tcnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      S_IDLE: begin
        if (tick && cfg_q[3] && !tx_empty) begin
          tx_pop     = 1'b1;
          tx_state_d = S_START;
          tx_tcnt_d  = '0;
          tx_bit_d   = '0;
          tx_shift_d = tx_dout;
          tx_par_d   = (^tx_dout) ^ par_odd;
        end
      end
      default: begin
        if (tick) begin
          tx_tcnt_d = tx_tcnt_q + 4'd1;
          if (tx_tcnt_q == 4'd15) begin
            case (tx_state_q)
              S_START: begin
                tx_state_d = S_DATA;
                tx_bit_d   = '0;
              end
              S_DATA: begin
                if (tx_bit_q == 3'(DATA_BITS - 1)) begin
                  tx_state_d = par_en ? S_PARITY : S_STOP;
                  tx_bit_d   = '0;
                end else begin
                  tx_shift_d = tx_shift_q >> 1;
                  tx_bit_d   = tx_bit_q + 3'd1;
                end
              end
              S_PARITY: begin
                tx_state_d = S_STOP;
                tx_bit_d   = '0;
              end
              default: begin
                if (cfg_q[2] && tx_bit_q == 3'd0) tx_bit_d = 3'd1;
                else                              tx_state_d = S_IDLE;
              end
            endcase
          end
        end
      end
    endcase
    case (tx_state_d)
      S_START:  tx_line_d = 1'b0;
      S_DATA:   tx_line_d = tx_shift_d[0];
      S_PARITY: tx_line_d = tx_par_d;
      default:  tx_line_d = 1'b1;
    endcase
  end

  // RX synchroniser, edge-detect history and FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_tcnt_q  <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_pbit_q  <= 1'b0;
    end else begin
      rx_s1_q    <= uart_rx;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_tcnt_q  <= rx_tcnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_pbit_q  <= rx_pbit_d;
    end
  end

  assign rx_sample  = tick && (rx_tcnt_q == 4'd7);
  assign rx_bit_end = tick && (rx_tcnt_q == 4'd15);
  assign ovr_set    = rx_push && rx_full && !rx_pop;

  // RX next state: mid-bit sampling, glitch rejection on the start bit, push on a good stop bit.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_tcnt_d  = rx_tcnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_pbit_d  = rx_pbit_q;
    rx_push    = 1'b0;
    frm_set    = 1'b0;
    perr_set   = 1'b0;
    if (rx_state_q != S_IDLE && tick) rx_tcnt_d = rx_tcnt_q + 4'd1;
    case (rx_state_q)
      S_IDLE: begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_state_d = S_START;
          rx_tcnt_d  = '0;
        end
      end
      S_START: begin
        if (rx_sample && rx_s2_q) begin
          rx_state_d = S_IDLE;
        end else if (rx_bit_end) begin
          rx_state_d = S_DATA;
          rx_bit_d   = '0;
        end
      end
      S_DATA: begin
        if (rx_sample) rx_shift_d = {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
        if (rx_bit_end) begin
          if (rx_bit_q == 3'(DATA_BITS - 1)) begin
            rx_state_d = par_en ? S_PARITY : S_STOP;
            rx_bit_d   = '0;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (rx_sample)  rx_pbit_d  = rx_s2_q;
        if (rx_bit_end) rx_state_d = S_STOP;
      end
      default: begin
        if (rx_sample) begin
          rx_state_d = S_IDLE;
          if (!rx_s2_q) begin
            frm_set = 1'b1;
          end else begin
            rx_push  = 1'b1;
            perr_set = par_en && (rx_pbit_q != ((^rx_shift_q) ^ par_odd));
          end
        end
      end
    endcase
    if (!cfg_q[4]) begin
      rx_state_d = S_IDLE;
      rx_push    = 1'b0;
      frm_set    = 1'b0;
      perr_set   = 1'b0;
    end
  end
endmodule

// File: tb/tb_uart_param.sv
// tb/tb_uart_param.sv - directed self-checking bench for uart_param
module tb_uart_param;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  reg_we, reg_re, reg_addr;
  logic [31:0] reg_di, reg_do;
  logic        ready, uart_rx, uart_tx;
  logic        loop_en, rx_drv;
  int          n_checks = 0;
  int          n_errors = 0;

  assign uart_rx = loop_en ? uart_tx : rx_drv;

  always #5 clk = ~clk;

  uart_param dut (
    .clk(clk), .reset(reset), .reg_we(reg_we), .reg_re(reg_re), .reg_addr(reg_addr),
    .reg_di(reg_di), .reg_do(reg_do), .ready(ready), .uart_rx(uart_rx), .uart_tx(uart_tx)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus(input logic we, input logic [3:0] addr, input logic [31:0] wdata,
                     output logic [31:0] rdata);
    logic got_rdy;
    @(negedge clk);
    reg_we   = we ? 4'hF : 4'h0;
    reg_re   = we ? 4'h0 : 4'hF;
    reg_addr = addr;
    reg_di   = wdata;
    got_rdy  = 1'b0;
    rdata    = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ready) begin
        got_rdy = 1'b1;
        rdata   = reg_do;
        break;
      end
    end
    reg_we = 4'h0;
    reg_re = 4'h0;
    check_eq("bus_ready", {31'd0, got_rdy}, 32'd1);
  endtask

  task automatic wr(input logic [3:0] addr, input logic [31:0] data);
    logic [31:0] dummy;
    bus(1'b1, addr, data, dummy);
  endtask

  task automatic rd_check(input string tag, input logic [3:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    bus(1'b0, addr, 32'd0, d);
    check_eq(tag, d, exp);
  endtask

  // Drives n serial bits LSB-first, each bit_clks clocks long, then idles high.
  task automatic drive_frame(input logic [15:0] bits, input int n, input int bit_clks);
    for (int i = 0; i < n; i++) begin
      rx_drv = bits[i];
      repeat (bit_clks) @(negedge clk);
    end
    rx_drv = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic        hi;
    logic        seen;
    int          low_len;
    logic [7:0]  exp_byte;

    reset = 1'b1; reg_we = '0; reg_re = '0; reg_addr = '0; reg_di = '0;
    loop_en = 1'b0; rx_drv = 1'b1;
    hi = 1'b1;
    repeat (5) begin
      @(negedge clk);
      hi &= uart_tx;
    end
    check_eq("reset_ready", {31'd0, ready}, 32'd0);
    check_eq("reset_do", reg_do, 32'd0);
    reset = 1'b0;
    rd_check("cfg_reset", 4'd0, 32'h18);
    rd_check("div_reset", 4'd1, 32'h0);
    rd_check("stat_reset", 4'd2, 32'h0A);
    hi &= uart_tx;
    check_eq("reset_tx_high", {31'd0, hi}, 32'd1);

    // CFG parity field writability and unmapped index behaviour
    wr(4'd0, 32'h1B);
`ifdef UART_PARAM_PARITY_EN
    rd_check("cfg_parity_wr", 4'd0, 32'h1B);
`else
    rd_check("cfg_parity_wr", 4'd0, 32'h18);
`endif
    wr(4'd0, 32'h18);
    wr(4'd7, 32'hFFFF_FFFF);
    rd_check("unmapped", 4'd7, 32'h0);

    // TX waveform at DIV=0: 16 clocks per bit
    exp_byte = 8'h55;
    wr(4'd3, 32'h55);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (!uart_tx) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check_eq("tx_start_seen", {31'd0, seen}, 32'd1);
    low_len = 0;
    for (int i = 0; i < 100; i++) begin
      if (uart_tx) break;
      low_len++;
      @(negedge clk);
    end
    check_eq("tx_start_len", 32'(low_len), 32'd16);
    repeat (7) @(negedge clk);
    check_eq("tx_bit0", {31'd0, uart_tx}, {31'd0, exp_byte[0]});
    for (int i = 1; i < 8; i++) begin
      repeat (16) @(negedge clk);
      check_eq("tx_bit", {31'd0, uart_tx}, {31'd0, exp_byte[i]});
    end
    repeat (16) @(negedge clk);
    check_eq("tx_stop", {31'd0, uart_tx}, 32'd1);
    repeat (20) @(negedge clk);
    rd_check("tx_done_stat", 4'd2, 32'h0A);

    // Loopback at DIV=3
    wr(4'd1, 32'd3);
    loop_en = 1'b1;
    wr(4'd3, 32'hA5);
    wr(4'd3, 32'h3C);
    repeat (1600) @(negedge clk);
    rd_check("loop_rx_a5", 4'd4, 32'hA5);
    rd_check("loop_rx_3c", 4'd4, 32'h3C);
    rd_check("loop_rx_empty", 4'd4, 32'h0);

    // Fill RX FIFO past full at DIV=0; the 17th character is dropped
    wr(4'd1, 32'd0);
    for (int i = 0; i < 16; i++) wr(4'd3, 32'h10 + 32'(i));
    repeat (200) @(negedge clk);
    wr(4'd3, 32'h20);
    repeat (3200) @(negedge clk);
    rd_check("fill_level", 4'd5, 32'h0010_0000);
    rd_check("fill_stat", 4'd2, 32'h16);
    wr(4'd2, 32'h10);
    rd_check("ovr_cleared", 4'd2, 32'h06);
    for (int i = 0; i < 16; i++) rd_check("drain", 4'd4, 32'h10 + 32'(i));
    rd_check("drain_empty", 4'd4, 32'h0);
    loop_en = 1'b0;

    // Stop bit of 0 at DIV=3 (64 clocks per bit)
    wr(4'd1, 32'd3);
    @(negedge clk);
    drive_frame(16'({1'b0, 8'h5A, 1'b0}), 10, 64);
    repeat (100) @(negedge clk);
    rd_check("frame_level", 4'd5, 32'h0);
    rd_check("frame_stat", 4'd2, 32'h2A);
    wr(4'd2, 32'h70);
    rd_check("frame_cleared", 4'd2, 32'h0A);

    // 4-clock glitch is rejected
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (4) @(negedge clk);
    rx_drv = 1'b1;
    repeat (200) @(negedge clk);
    rd_check("glitch_level", 4'd5, 32'h0);
    rd_check("glitch_stat", 4'd2, 32'h0A);

`ifdef UART_PARAM_PARITY_EN
    // Even parity, 0x07 has three ones so the correct parity bit is 1; send 0
    wr(4'd0, 32'h19);
    @(negedge clk);
    drive_frame(16'({1'b1, 1'b0, 8'h07, 1'b0}), 11, 64);
    repeat (100) @(negedge clk);
    rd_check("par_data", 4'd4, 32'h07);
    rd_check("par_stat", 4'd2, 32'h4A);
`else
    @(negedge clk);
    drive_frame(16'({1'b1, 8'h07, 1'b0}), 10, 64);
    repeat (100) @(negedge clk);
    rd_check("plain_data", 4'd4, 32'h07);
    rd_check("plain_stat", 4'd2, 32'h0A);
`endif

    // Reset in the middle of a frame returns the line high on the next clock
    wr(4'd3, 32'h00);
    repeat (100) @(negedge clk);
    check_eq("midframe_low", {31'd0, uart_tx}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check_eq("midframe_reset_tx", {31'd0, uart_tx}, 32'd1);
    reset = 1'b0;
    rd_check("post_reset_stat", 4'd2, 32'h0A);
    rd_check("post_reset_cfg", 4'd0, 32'h18);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
